// File: rtl/matmul_seq_ctrl.sv
// Loop-nest sequencer for the single-MAC matrix multiplier.
// Issues i/j/k SRAM read addresses and MAC strobes aligned to read data.
module matmul_seq_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_valid,
    output logic              start_ready,
    output logic [ADDR_W-1:0] in_rd_addr,
    output logic [ADDR_W-1:0] wt_rd_addr,
    input  logic [31:0]       in_rd_data,
    input  logic [31:0]       wt_rd_data,
    output logic              mac_en,
    output logic              mac_first,
    output logic              mac_last,
    output logic [ADDR_W-1:0] res_wr_addr,
    output logic              done,
    output logic              dim_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DIM_RD = 3'd1;
    localparam logic [2:0] S_DIM_LD = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_DRAIN  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]        r_state;
    logic [2:0]        w_nxt;
    logic              r_start_ready;
    logic              r_done;
    logic              r_dim_err;
    logic              r_mac_en;
    logic              r_mac_first;
    logic              r_mac_last;
    logic [ADDR_W-1:0] r_res;
    logic [ADDR_W-1:0] r_in_addr;
    logic [ADDR_W-1:0] r_wt_addr;
    logic [ADDR_W-1:0] r_a_base;
    logic [ADDR_W-1:0] r_b_base;
    logic [DIM_W-1:0]  r_m;
    logic [DIM_W-1:0]  r_kd;
    logic [DIM_W-1:0]  r_n;
    logic [DIM_W-1:0]  r_k2;
    logic [CNT_W-1:0]  r_i;
    logic [CNT_W-1:0]  r_j;
    logic [CNT_W-1:0]  r_k;

    logic              w_accept;
    logic              w_err;
    logic              w_run;
    logic              w_k_end;
    logic              w_j_end;
    logic              w_i_end;
    logic              w_last;
    logic [ADDR_W-1:0] w_kstep;

    assign w_accept = start_valid && r_start_ready;
    assign w_err    = (r_m == '0) || (r_kd == '0) || (r_n == '0) || (r_kd != r_k2);
    assign w_run    = (r_state == S_RUN);
    assign w_k_end  = (r_k == CNT_W'(r_kd) - CNT_W'(1));
    assign w_j_end  = (r_j == CNT_W'(r_n) - CNT_W'(1));
    assign w_i_end  = (r_i == CNT_W'(r_m) - CNT_W'(1));
    assign w_last   = w_k_end && w_j_end && w_i_end;
    assign w_kstep  = ADDR_W'(r_kd);

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            S_IDLE:   w_nxt = w_accept ? S_DIM_RD : S_IDLE;
            S_DIM_RD: w_nxt = S_DIM_LD;
            S_DIM_LD: w_nxt = S_CHECK;
            S_CHECK:  w_nxt = w_err ? S_DONE : S_RUN;
            S_RUN:    w_nxt = w_last ? S_DRAIN : S_RUN;
            S_DRAIN:  w_nxt = S_DONE;
            S_DONE:   w_nxt = S_IDLE;
            default:  w_nxt = S_IDLE;
        endcase
    end

    // Control, status and one-stage-delayed MAC strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_start_ready <= 1'b1;
            r_done        <= 1'b0;
            r_dim_err     <= 1'b0;
            r_mac_en      <= 1'b0;
            r_mac_first   <= 1'b0;
            r_mac_last    <= 1'b0;
            r_res         <= '0;
            r_m           <= '0;
            r_kd          <= '0;
            r_n           <= '0;
            r_k2          <= '0;
        end else begin
            r_state       <= w_nxt;
            r_start_ready <= (w_nxt == S_IDLE);
            r_done        <= (w_nxt == S_DONE);
            r_mac_en      <= w_run;
            r_mac_first   <= w_run && (r_k == '0);
            r_mac_last    <= w_run && w_k_end;
            if (w_accept) begin
                r_dim_err <= 1'b0;
                r_res     <= '0;
            end else begin
                if (r_state == S_CHECK)
                    r_dim_err <= w_err;
                if (r_mac_last)
                    r_res <= r_res + ADDR_W'(1);
            end
            if (r_state == S_DIM_LD) begin
                r_m  <= DIM_W'(in_rd_data[31:16]);
                r_kd <= DIM_W'(in_rd_data[15:0]);
                r_k2 <= DIM_W'(wt_rd_data[31:16]);
                r_n  <= DIM_W'(wt_rd_data[15:0]);
            end
        end
    end

    // Incremental address walk; registers hold the address being issued
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i       <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_a_base  <= '0;
            r_b_base  <= '0;
            r_in_addr <= '0;
            r_wt_addr <= '0;
        end else if (r_state == S_CHECK) begin
            r_i       <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_a_base  <= '0;
            r_b_base  <= '0;
            r_in_addr <= w_err ? '0 : ADDR_W'(1);
            r_wt_addr <= w_err ? '0 : ADDR_W'(1);
        end else if (w_run) begin
            if (w_last) begin
                r_in_addr <= '0;
                r_wt_addr <= '0;
            end else if (!w_k_end) begin
                r_k       <= r_k + CNT_W'(1);
                r_in_addr <= r_a_base + r_k[ADDR_W-1:0] + ADDR_W'(2);
                r_wt_addr <= r_b_base + r_k[ADDR_W-1:0] + ADDR_W'(2);
            end else if (!w_j_end) begin
                r_k       <= '0;
                r_j       <= r_j + CNT_W'(1);
                r_b_base  <= r_b_base + w_kstep;
                r_in_addr <= r_a_base + ADDR_W'(1);
                r_wt_addr <= r_b_base + w_kstep + ADDR_W'(1);
            end else begin
                r_k       <= '0;
                r_j       <= '0;
                r_i       <= r_i + CNT_W'(1);
                r_b_base  <= '0;
                r_a_base  <= r_a_base + w_kstep;
                r_in_addr <= r_a_base + w_kstep + ADDR_W'(1);
                r_wt_addr <= ADDR_W'(1);
            end
        end
    end

    assign start_ready = r_start_ready;
    assign in_rd_addr  = r_in_addr;
    assign wt_rd_addr  = r_wt_addr;
    assign mac_en      = r_mac_en;
    assign mac_first   = r_mac_first;
    assign mac_last    = r_mac_last;
    assign res_wr_addr = r_res;
    assign done        = r_done;
    assign dim_err     = r_dim_err;

endmodule

// File: doc/matmul_seq_ctrl.md
# matmul_seq_ctrl

Loop-nest sequencer for the single-MAC matrix multiplier. On a start handshake it reads the dimension words at address 0 of the input and weight SRAMs and checks them. It then issues one input/weight read-address pair per cycle in i/j/k order, with MAC control strobes aligned to the returning SRAM data and the result-SRAM address for every finished dot product. It contains no arithmetic datapath: the FP MAC, its accumulator register and the result-write register sit downstream and are driven from this block's strobes.

## Interface
- ADDR_W, 16, SRAM address width
- DIM_W, 16, width of each dimension field (two fields packed into one 32-bit word)
- CNT_W, 32, width of the internal output/term counters
- clk  in  1  clock
- reset_n  in  1  reset; asynchronous, active-low
- start_valid  in  1  job request
- start_ready  out  1  high only in IDLE; a job is accepted when start_valid && start_ready
- in_rd_addr  out  ADDR_W  input SRAM read address (1-cycle read latency)
- wt_rd_addr  out  ADDR_W  weight SRAM read address
- in_rd_data  in  32  input SRAM read data; {M[31:16], K[15:0]} when reading address 0
- wt_rd_data  in  32  weight SRAM read data; {K2[31:16], N[15:0]} when reading address 0
- mac_en  out  1  the SRAM data presented this cycle is a valid A×B term
- mac_first  out  1  with mac_en: first term (k=0), so the accumulator input is forced to 0
- mac_last  out  1  with mac_en: last term (k=K-1), so the MAC output is a finished C element
- res_wr_addr  out  ADDR_W  result address of the current dot product; valid while mac_en
- done  out  1  one-cycle pulse at job end (normal or error)
- dim_err  out  1  last job was rejected; held until the next accept

## Operation
- Memory layout:
  - A[i][k] is at in_rd_addr = 1 + i·K + k (row-major).
  - B[k][j] is at wt_rd_addr = 1 + j·K + k (column-major).
  - C[i][j] is at res_wr_addr = i·N + j.
- FSM states: IDLE → DIM_RD → DIM_LD → CHECK → RUN → DRAIN → DONE → IDLE.
  - IDLE: both read addresses are 0. Go to DIM_RD on accept.
  - DIM_RD: both read addresses are 0.
  - DIM_LD: capture M, K, N, K2 from the read data.
  - CHECK: dim_err = (M==0) | (K==0) | (N==0) | (K≠K2). On error go to DONE; otherwise go to RUN.
  - RUN: issue one address pair per cycle for M·N·K cycles, then go to DRAIN.
  - DRAIN: one cycle covering the final aligned strobe.
  - DONE: done=1 for one cycle.
- Address generation is incremental, with no multipliers. Counters k, j, i and bases a_base, b_base:
  - Each cycle: in_rd_addr = a_base+k+1 and wt_rd_addr = b_base+k+1.
  - When k reaches K-1: k←0, j++, b_base += K.
  - When j also reaches N-1: j←0, b_base←0, a_base += K, i++.
  - The final issue is i=M-1, j=N-1, k=K-1.
- Strobes: mac_en, mac_first and mac_last are the issue-cycle flags (valid, k==0, k==K-1) delayed by exactly one register stage. This aligns them with the SRAM data.
- res_wr_addr: an up-counter starting at 0, advanced on each mac_last cycle, and held between mac_last cycles.
- Width rules:
  - Addresses wrap modulo 2^ADDR_W.
  - The bench keeps M·K+1 and K·N+1 < 2^ADDR_W.
  - The internal term count M·N·K must fit in CNT_W.
- start_valid while busy is ignored and is not queued.
- K=1: every mac_en cycle has mac_first=mac_last=1.
- Mid-job reset: asynchronous return to IDLE. All counters clear, no strobes, no done pulse.

## Timing
- Reset values:
  - start_ready=1.
  - All other outputs 0: in_rd_addr, wt_rd_addr, mac_en, mac_first, mac_last, res_wr_addr, done, dim_err.
- Cycle 0 is the accept edge. Sequence:
  - DIM_RD: cycle 1.
  - DIM_LD: cycle 2.
  - CHECK: cycle 3.
  - First RUN issue: cycle 4.
  - First mac_en: cycle 5.
  - Last mac_en: cycle 4+M·N·K.
  - done: cycle 5+M·N·K.
  - IDLE with start_ready=1: cycle 6+M·N·K.
- Error path: done=1 and dim_err=1 in cycle 4. IDLE in cycle 5. No mac_en is ever asserted.
- start_ready is 0 from cycle 1 through the DONE cycle inclusive.
- dim_err clears on the accept cycle of the next job.
- All outputs are registered. There is no combinational path from input to output.

## Test plan
- Reset: hold reset_n low with random inputs → start_ready=1, all other outputs 0. Assert reset in RUN cycle 3 of a job → IDLE immediately, no done.
- Nominal M=2, K=3, N=2:
  - in_rd_addr issues 1,2,3,1,2,3,4,5,6,4,5,6 in cycles 4–15.
  - wt_rd_addr issues 1..6,1..6 in cycles 4–15.
  - mac_last in cycles 7, 10, 13, 16 with res_wr_addr 0, 1, 2, 3.
  - done in cycle 17.
- K=1, M=1, N=3: mac_en with first=last=1 in cycles 5–7, res_wr_addr 0, 1, 2, done in cycle 8.
- Dimension mismatch {2,3} vs {4,2} → dim_err=1 and done in cycle 4, no mac_en. The next valid job clears dim_err on accept.
- Zero dimension M=0 → same as the error path. Then a back-to-back start held high → the second job is accepted exactly on the first IDLE cycle.
- start_valid pulsed during RUN → ignored: address sequence and done timing identical to the nominal case.
